synch_req_gen_ipa: RTL and testbench

- Issuing end of the per-transfer synch (release) interface.
- One instance sits beside each TX or RX data path (TCDM or EXT side) of the DMA channel.
- Queues the accepted commands with their transfer SID and beat count, and counts completed data beats against the command at the head of the queue.
- Emits one single-cycle synch_req/synch_sid release per command when that command's last beat completes.

---
 rtl/mchan_ipa_pkg.sv | 32 +++
 rtl/synch_cmd_fifo_ipa.sv | 66 ++++++
 rtl/synch_req_gen_ipa.sv | 155 +++++++++++++++
 tb/tb_synch_req_gen_ipa.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mchan_ipa_pkg.sv
// Shared types and helpers for the DMA channel synch (release) interface.
// Widths here are the channel defaults; blocks re-derive their own from parameters.
package mchan_ipa_pkg;

    localparam int unsigned DEF_SID_WIDTH = 2;
    localparam int unsigned DEF_LEN_WIDTH = 15;

    typedef struct packed {
        logic [DEF_SID_WIDTH-1:0] sid;
        logic [DEF_LEN_WIDTH-1:0] nb_beats;
    } synch_cmd_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } synch_state_e;

    // Beats covered by a command whose length field is byte count minus one.
    // beat_bytes is a power of two; the shift folds to a constant when it is a parameter.
    function automatic logic [31:0] beats_from_len(input logic [31:0] len,
                                                   input int unsigned beat_bytes);
        int unsigned shift;
        shift = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) == beat_bytes) begin
                shift = unsigned'(i);
            end
        end
        return (len >> shift) + 32'd1;
    endfunction

endpackage

// File: rtl/synch_cmd_fifo_ipa.sv
// Command queue for the synch request generator: push at tail, pop at head,
// with the head and the entry behind it both readable from registered state.
module synch_cmd_fifo_ipa #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [WIDTH-1:0]             next_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_next_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer MSB tells a full queue from an empty one.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign rd_next_ptr = rd_ptr_q + PTR_W'(1);
    assign head_o      = mem_q[rd_ptr_q[AW-1:0]];
    assign next_o      = mem_q[rd_next_ptr[AW-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_next_ptr;
            end
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only read after a
    // push has written it, and the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/synch_req_gen_ipa.sv
// Issuing end of the per-transfer synch interface: queues commands, counts
// completed beats against the head command and pulses one release per command.
module synch_req_gen_ipa
    import mchan_ipa_pkg::*;
#(
    parameter int unsigned TRANS_SID_WIDTH = DEF_SID_WIDTH,
    parameter int unsigned MCHAN_LEN_WIDTH = DEF_LEN_WIDTH,
    parameter int unsigned BEAT_BYTES      = 8,
    parameter int unsigned CMD_FIFO_DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cmd_req_i,
    output logic                       cmd_gnt_o,
    input  logic [TRANS_SID_WIDTH-1:0] cmd_sid_i,
    input  logic [MCHAN_LEN_WIDTH-1:0] cmd_len_i,
    input  logic                       beat_valid_i,
    input  logic                       beat_ready_i,
    output logic                       synch_req_o,
    output logic [TRANS_SID_WIDTH-1:0] synch_sid_o,
    output logic                       busy_o,
    output logic                       beat_err_o
);

    localparam int unsigned ENTRY_W = TRANS_SID_WIDTH + MCHAN_LEN_WIDTH;
    localparam int unsigned PTR_W   = $clog2(CMD_FIFO_DEPTH) + 1;
    localparam logic [MCHAN_LEN_WIDTH-1:0] ONE_BEAT = MCHAN_LEN_WIDTH'(1);

    typedef struct packed {
        logic [TRANS_SID_WIDTH-1:0] sid;
        logic [MCHAN_LEN_WIDTH-1:0] nb_beats;
    } entry_t;

    entry_t                     push_entry;
    logic [ENTRY_W-1:0]         head_raw;
    logic [ENTRY_W-1:0]         next_raw;
    entry_t                     head_entry;
    entry_t                     next_entry;
    logic                       push;
    logic                       pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [PTR_W-1:0]           fifo_count;
    logic [PTR_W-1:0]           count_next;
    logic                       beat_fire;

    synch_state_e               state_q, state_d;
    logic [MCHAN_LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [TRANS_SID_WIDTH-1:0] sid_q, sid_d;
    logic                       synch_req_q, synch_req_d;
    logic [TRANS_SID_WIDTH-1:0] synch_sid_q, synch_sid_d;
    logic                       beat_err_q, beat_err_d;
    logic                       busy_q, busy_d;

    // Grant depends only on registered fullness, so a same-cycle pop never
    // makes room for a same-cycle push.
    assign cmd_gnt_o = !fifo_full;
    assign push      = cmd_req_i && !fifo_full;
    assign beat_fire = beat_valid_i && beat_ready_i;

    assign push_entry.sid      = cmd_sid_i;
    assign push_entry.nb_beats = MCHAN_LEN_WIDTH'(beats_from_len(32'(cmd_len_i), BEAT_BYTES));

    synch_cmd_fifo_ipa #(
        .WIDTH (ENTRY_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .head_o  (head_raw),
        .next_o  (next_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_entry = entry_t'(head_raw);
    assign next_entry = entry_t'(next_raw);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sid_d       = sid_q;
        pop         = 1'b0;
        synch_req_d = 1'b0;
        synch_sid_d = synch_sid_q;
        beat_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                beat_err_d = beat_fire;
                if (!fifo_empty) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = head_entry.nb_beats;
                    sid_d   = head_entry.sid;
                end
            end
            ST_ACTIVE: begin
                if (beat_fire) begin
                    if (cnt_q == ONE_BEAT) begin
                        pop         = 1'b1;
                        synch_req_d = 1'b1;
                        synch_sid_d = sid_q;
                        // The entry behind the head takes over on the same edge.
                        if (fifo_count > PTR_W'(1)) begin
                            cnt_d = next_entry.nb_beats;
                            sid_d = next_entry.sid;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE_BEAT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign count_next = fifo_count + PTR_W'(push) - PTR_W'(pop);
    assign busy_d     = (count_next != '0) || (state_d == ST_ACTIVE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sid_q       <= '0;
            synch_req_q <= 1'b0;
            synch_sid_q <= '0;
            beat_err_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sid_q       <= sid_d;
            synch_req_q <= synch_req_d;
            synch_sid_q <= synch_sid_d;
            beat_err_q  <= beat_err_d;
            busy_q      <= busy_d;
        end
    end

    assign synch_req_o = synch_req_q;
    assign synch_sid_o = synch_sid_q;
    assign beat_err_o  = beat_err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_synch_req_gen_ipa.sv
// Scoreboard bench for synch_req_gen_ipa: a queue-of-commands model predicts
// release pulses and beat errors; a monitor checks them cycle by cycle.
module tb_synch_req_gen_ipa;

    localparam int SID_W      = 2;
    localparam int LEN_W      = 15;
    localparam int BEAT_BYTES = 8;
    localparam int DEPTH      = 4;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             cmd_req_i = 1'b0;
    logic             cmd_gnt_o;
    logic [SID_W-1:0] cmd_sid_i = '0;
    logic [LEN_W-1:0] cmd_len_i = '0;
    logic             beat_valid_i = 1'b0;
    logic             beat_ready_i = 1'b0;
    logic             synch_req_o;
    logic [SID_W-1:0] synch_sid_o;
    logic             busy_o;
    logic             beat_err_o;

    always #5 clk = ~clk;

    synch_req_gen_ipa #(
        .TRANS_SID_WIDTH (SID_W),
        .MCHAN_LEN_WIDTH (LEN_W),
        .BEAT_BYTES      (BEAT_BYTES),
        .CMD_FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .cmd_req_i    (cmd_req_i),
        .cmd_gnt_o    (cmd_gnt_o),
        .cmd_sid_i    (cmd_sid_i),
        .cmd_len_i    (cmd_len_i),
        .beat_valid_i (beat_valid_i),
        .beat_ready_i (beat_ready_i),
        .synch_req_o  (synch_req_o),
        .synch_sid_o  (synch_sid_o),
        .busy_o       (busy_o),
        .beat_err_o   (beat_err_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [SID_W-1:0] sid;
        int               cyc;
    } rel_t;

    typedef struct {
        logic [SID_W-1:0] sid;
        int               rem;
    } cmd_t;

    rel_t             rel_q[$];
    int               err_q[$];
    cmd_t             m_q[$];
    bit               m_loaded = 1'b0;
    bit               m_busy = 1'b0;
    logic [SID_W-1:0] m_last_sid = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle, release and error pulses must match the scoreboard exactly.
    initial begin
        forever begin
            @(negedge clk);
            begin
                bit exp_rel;
                bit exp_err;
                exp_rel = (rel_q.size() != 0) && (rel_q[0].cyc == cyc);
                check("synch_req", 32'(synch_req_o), 32'(exp_rel));
                if (exp_rel) begin
                    rel_t r;
                    r = rel_q.pop_front();
                    check("synch_sid", 32'(synch_sid_o), 32'(r.sid));
                end
                exp_err = (err_q.size() != 0) && (err_q[0] == cyc);
                check("beat_err", 32'(beat_err_o), 32'(exp_err));
                if (exp_err) begin
                    void'(err_q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus; called at a negedge, returns at the next negedge.
    task automatic step(input bit req, input logic [SID_W-1:0] sid, input logic [LEN_W-1:0] len,
                        input bit bv, input bit br);
        bit gnt;
        bit fire;
        int n_before;
        check("cmd_gnt", 32'(cmd_gnt_o), 32'(m_q.size() < DEPTH));
        check("busy", 32'(busy_o), 32'(m_busy));
        check("synch_sid_hold", 32'(synch_sid_o), 32'(m_last_sid));

        cmd_req_i    = req;
        cmd_sid_i    = sid;
        cmd_len_i    = len;
        beat_valid_i = bv;
        beat_ready_i = br;

        gnt      = m_q.size() < DEPTH;
        fire     = bv && br;
        n_before = m_q.size();
        if (m_loaded) begin
            if (fire) begin
                m_q[0].rem = m_q[0].rem - 1;
                if (m_q[0].rem == 0) begin
                    rel_q.push_back('{m_q[0].sid, cyc + 1});
                    m_last_sid = m_q[0].sid;
                    void'(m_q.pop_front());
                    m_loaded = (m_q.size() != 0);
                end
            end
        end else begin
            if (fire) err_q.push_back(cyc + 1);
            if (n_before != 0) m_loaded = 1'b1;
        end
        if (req && gnt) m_q.push_back('{sid, int'(len) / BEAT_BYTES + 1});
        m_busy = (m_q.size() != 0) || m_loaded;

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_synch_req"}, 32'(synch_req_o), 32'd0);
        check({tag, "_synch_sid"}, 32'(synch_sid_o), 32'd0);
        check({tag, "_beat_err"}, 32'(beat_err_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_cmd_gnt"}, 32'(cmd_gnt_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        @(negedge clk);

        // Single 4-beat command.
        step(1'b1, 2'd2, 15'd31, 1'b0, 1'b0);
        idle(2);
        beats(4);
        idle(3);

        // Three commands, beats streamed back to back.
        step(1'b1, 2'd0, 15'd7, 1'b0, 1'b0);
        step(1'b1, 2'd1, 15'd7, 1'b0, 1'b0);
        step(1'b1, 2'd3, 15'd15, 1'b0, 1'b0);
        idle(1);
        beats(4);
        idle(3);

        // Fill the queue, then a last beat together with a refused request.
        for (int i = 0; i < 5; i++) step(1'b1, SID_W'(i), 15'd0, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 2'd1, 15'd0, 1'b1, 1'b1);
        beats(4);
        idle(2);

        // Beats with nothing queued.
        beats(3);
        idle(2);

        // Valid held, ready toggling: len=23 needs three handshakes.
        step(1'b1, 2'd1, 15'd23, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, (i % 2) == 1);
        idle(2);

        // Reset in the middle of a transfer with two commands queued.
        step(1'b1, 2'd2, 15'd31, 1'b0, 1'b0);
        step(1'b1, 2'd3, 15'd31, 1'b0, 1'b0);
        idle(2);
        beats(2);
        #2;
        rst_ni       = 1'b0;
        cmd_req_i    = 1'b0;
        beat_valid_i = 1'b0;
        beat_ready_i = 1'b0;
        #1;
        check_reset_outputs("midreset");
        m_q.delete();
        rel_q.delete();
        err_q.delete();
        m_loaded   = 1'b0;
        m_busy     = 1'b0;
        m_last_sid = '0;
        repeat (2) @(negedge clk);
        #2;
        rst_ni = 1'b1;
        @(negedge clk);
        idle(10);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 2) == 0, SID_W'($urandom_range(0, 3)),
                 LEN_W'($urandom_range(0, 63)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1);
        end

        guard = 0;
        while (((m_q.size() != 0) || m_loaded) && guard < 300) begin
            step(1'b0, '0, '0, 1'b1, 1'b1);
            guard++;
        end
        check("drain_done", 32'(m_q.size()), 32'd0);
        idle(3);
        check("scoreboard_empty", 32'(rel_q.size() + err_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
